// File: rtl/param_rf_pkg.sv
// Shared types and helpers for the parametrised register file.
// Latency: none (types and pure functions only).
// Backpressure: none.
package param_rf_pkg;

  // Sequencer states: INIT walks every entry, RUN serves user traffic.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_state_t;

  // Upper bound on write ports handled by the winner search.
  localparam int MAX_PORTS = 32;

  // Given the per-port "this port writes the address" mask, return the
  // highest-index port that hits, or -1 when no port hits.
  function automatic int win_port(input logic [MAX_PORTS-1:0] hit);
    int w;
    w = -1;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (hit[i]) w = i;
    end
    return w;
  endfunction

  // Unsigned range check of an address against the number of entries.
  function automatic logic addr_ok(input logic [31:0] addr, input logic [31:0] depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/param_rf_init_seq.sv
// Init/clear sequencer: walks every entry once after reset or on clear_req.
// Latency: DEPTH cycles of INIT, ready rises the cycle after the last walk write.
// Backpressure: none; clear_req is only honoured in RUN, ignored during INIT.
module param_rf_init_seq
  import param_rf_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr,
  output logic              ready
);

  rf_state_t         state, state_nxt;
  logic [ADDR_W-1:0] init_ptr, init_ptr_nxt;

  // State and walk pointer; reset restarts the walk from entry 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= INIT;
      init_ptr <= '0;
    end else begin
      state    <= state_nxt;
      init_ptr <= init_ptr_nxt;
    end
  end

  // Next-state and walk control; pointer stops at DEPTH-1 and never wraps.
  always_comb begin
    state_nxt    = state;
    init_ptr_nxt = init_ptr;
    init_we      = 1'b0;
    ready        = 1'b0;
    case (state)
      INIT: begin
        init_we = 1'b1;
        if (init_ptr == ADDR_W'(DEPTH - 1)) begin
          state_nxt    = RUN;
          init_ptr_nxt = '0;
        end else begin
          init_ptr_nxt = init_ptr + ADDR_W'(1);
        end
      end
      RUN: begin
        ready = 1'b1;
        if (clear_req) begin
          state_nxt    = INIT;
          init_ptr_nxt = '0;
        end
      end
      default: begin
        state_nxt    = INIT;
        init_ptr_nxt = '0;
      end
    endcase
  end

  assign init_addr = init_ptr;

endmodule

// File: rtl/param_rf.sv
// Multi-port register file with init/clear walk, optional bypass and read register.
// Latency: writes land at the edge; reads are combinational or one cycle (RD_LATENCY).
// Backpressure: writes are dropped and reads return 0 while ready is low.
module param_rf
  import param_rf_pkg::*;
#(
  parameter int              DATA_W     = 13,
  parameter int              DEPTH      = 16,
  parameter int              ADDR_W     = 7,
  parameter int              RD_PORTS   = 2,
  parameter int              WR_PORTS   = 2,
  parameter int              RD_LATENCY = 0,
  parameter int              BYPASS     = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear_req,
  output logic                         ready,
  input  logic [WR_PORTS-1:0]          we,
  input  logic [WR_PORTS*ADDR_W-1:0]   waddr,
  input  logic [WR_PORTS*DATA_W-1:0]   wdata,
  input  logic [RD_PORTS*ADDR_W-1:0]   raddr,
  output logic [RD_PORTS*DATA_W-1:0]   rdata,
  output logic [RD_PORTS-1:0]          rd_oob
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              init_we;
  logic [ADDR_W-1:0] init_addr;

  param_rf_init_seq #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_init_seq (
    .clk      (clk),
    .reset    (reset),
    .clear_req(clear_req),
    .init_we  (init_we),
    .init_addr(init_addr),
    .ready    (ready)
  );

  // A user write port is live only in RUN and only for in-range addresses.
  logic [WR_PORTS-1:0] wr_ok;
  always_comb begin
    wr_ok = '0;
    for (int i = 0; i < WR_PORTS; i++) begin
      wr_ok[i] = we[i] && ready &&
                 addr_ok(32'(waddr[i*ADDR_W +: ADDR_W]), 32'(DEPTH));
    end
  end

  // Per-entry write select: the init walk, else the highest-index hitting port.
  logic [DEPTH-1:0]  ent_wr;
  logic [DATA_W-1:0] ent_dat [DEPTH];
  always_comb begin
    logic [WR_PORTS-1:0] hit;
    int                  w;
    hit = '0;
    w   = -1;
    for (int e = 0; e < DEPTH; e++) begin
      ent_wr[e]  = 1'b0;
      ent_dat[e] = '0;
      if (init_we && (init_addr == ADDR_W'(e))) begin
        ent_wr[e]  = 1'b1;
        ent_dat[e] = INIT_VAL;
      end else begin
        for (int i = 0; i < WR_PORTS; i++) begin
          hit[i] = wr_ok[i] && (waddr[i*ADDR_W +: ADDR_W] == ADDR_W'(e));
        end
        w = win_port(MAX_PORTS'(hit));
        if (w >= 0) begin
          ent_wr[e]  = 1'b1;
          ent_dat[e] = wdata[w*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Storage update; contents are defined by the init walk, not by reset.
  always_ff @(posedge clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (ent_wr[e]) mem[e] <= ent_dat[e];
    end
  end

  // Read lookup with optional same-cycle forwarding; zero while not ready.
  logic [RD_PORTS*DATA_W-1:0] rd_dat;
  logic [RD_PORTS-1:0]        rd_oob_c;
  always_comb begin
    logic [ADDR_W-1:0]   ra;
    logic [WR_PORTS-1:0] bhit;
    int                  bw;
    rd_dat   = '0;
    rd_oob_c = '0;
    ra       = '0;
    bhit     = '0;
    bw       = -1;
    for (int j = 0; j < RD_PORTS; j++) begin
      ra = raddr[j*ADDR_W +: ADDR_W];
      if (ready) begin
        if (!addr_ok(32'(ra), 32'(DEPTH))) begin
          rd_oob_c[j] = 1'b1;
        end else begin
          for (int e = 0; e < DEPTH; e++) begin
            if (ra == ADDR_W'(e)) rd_dat[j*DATA_W +: DATA_W] = mem[e];
          end
          if (BYPASS != 0) begin
            for (int i = 0; i < WR_PORTS; i++) begin
              bhit[i] = wr_ok[i] && (waddr[i*ADDR_W +: ADDR_W] == ra);
            end
            bw = win_port(MAX_PORTS'(bhit));
            if (bw >= 0) rd_dat[j*DATA_W +: DATA_W] = wdata[bw*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  generate
    if (RD_LATENCY == 0) begin : g_rd_comb
      assign rdata  = rd_dat;
      assign rd_oob = rd_oob_c;
    end else begin : g_rd_reg
      // Registered read: samples the lookup (including forwarded data) each edge.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rdata  <= '0;
          rd_oob <= '0;
        end else begin
          rdata  <= rd_dat;
          rd_oob <= rd_oob_c;
        end
      end
    end
  endgenerate

endmodule

// File: doc/param_rf.md
Name: param_rf

Overview:
- Parametrised multi-port register file; successor to the single-read/single-write flop RF.
- Configurable width, depth, read-port count, write-port count, read latency and write-to-read bypass.
- Built-in init/clear sequencer: walks every entry writing INIT_VAL after reset or on request.
- Used as a synthesis and translation test block and as a generic storage primitive.

Parameters:
- DATA_W, 13, entry width in bits
- DEPTH, 16, number of entries (at least 2)
- ADDR_W, 7, address width; must satisfy 2**ADDR_W >= DEPTH
- RD_PORTS, 2, number of read ports
- WR_PORTS, 2, number of write ports
- RD_LATENCY, 0, 0 = combinational read, 1 = registered read
- BYPASS, 1, 1 = a same-cycle write to the read address is forwarded to the read data
- INIT_VAL, 0, DATA_W-bit value written to every entry by the init sequencer

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- clear_req  in  1  request a full re-initialisation (sampled in RUN only)
- ready  out  1  high when the RF accepts writes and returns valid reads
- we  in  WR_PORTS  per-port write enable
- waddr  in  WR_PORTS*ADDR_W  write addresses, port i in bits [i*ADDR_W +: ADDR_W]
- wdata  in  WR_PORTS*DATA_W  write data, same packing
- raddr  in  RD_PORTS*ADDR_W  read addresses, same packing
- rdata  out  RD_PORTS*DATA_W  read data, same packing
- rd_oob  out  RD_PORTS  per-port flag: read address >= DEPTH

Behaviour:
- Reset: FSM goes to INIT with init_ptr=0. Outputs: ready=0, registered rdata=0, registered rd_oob=0. Array contents are not reset directly; the INIT walk defines them.
- INIT state:
  - Each cycle writes INIT_VAL to entry init_ptr, then init_ptr increments.
  - After the write to DEPTH-1 the FSM moves to RUN.
  - ready rises on the cycle after the last init write, i.e. DEPTH cycles after reset deasserts.
- INIT restrictions:
  - User writes are dropped.
  - rdata reads 0 and rd_oob reads 0.
  - clear_req is ignored; no restart.
- RUN state:
  - ready=1.
  - clear_req=1 enters INIT on the next edge with init_ptr=0.
  - User writes in the same cycle as clear_req are performed first, then overwritten by the walk.
- A reset asserted mid-INIT or mid-RUN restarts INIT immediately; any partial walk is abandoned.
- Writes (RUN only):
  - The entry at waddr[i] is updated at the clock edge when we[i]=1 and waddr[i] < DEPTH.
  - If waddr[i] >= DEPTH the write is silently dropped.
  - Several ports writing the same address in one cycle: the highest-index port wins.
- Reads, RD_LATENCY=0:
  - rdata[j] is combinational from the array, giving pre-edge contents.
  - If BYPASS=1 and an enabled in-range write targets raddr[j] this cycle, the write data (highest-index winner) is forwarded combinationally.
- Reads, RD_LATENCY=1:
  - rdata[j] and rd_oob[j] are registered; the value is sampled at edge k and visible after edge k.
  - BYPASS=1: the register captures the data written at the same edge.
  - BYPASS=0: the register captures the old contents.
- Out-of-range read (raddr[j] >= DEPTH): rdata[j]=0 and rd_oob[j]=1, with the same latency as data.
- Read ports are fully independent; any number of them may hit the same address.
- Widths:
  - Address compares are unsigned at ADDR_W bits.
  - init_ptr is ADDR_W bits and never wraps past DEPTH-1.

Decomposition:
- Package param_rf_pkg holds:
  - FSM state enum (INIT, RUN);
  - a function returning the winning write port for an address;
  - the address-range check.
- Sub-module param_rf_init_seq holds the FSM plus init_ptr.
  - Outputs: init_we, init_addr, ready.
  - Input: clear_req.
- The top module instantiates it and muxes init writes over user writes.

Test Plan (defaults unless stated):
- Reset release: ready=0 for 16 cycles and 1 on cycle 16; reading all 16 addresses afterwards returns 0.
- Port priority: we=2'b11, waddr0=waddr1=5, wdata0=0x0AA, wdata1=0x155; the next-cycle read of address 5 returns 0x155.
- Bypass, RD_LATENCY=0:
  - BYPASS=1, write 0x1234 to address 3 while raddr0=3: rdata0=0x1234 in the same cycle.
  - BYPASS=0: rdata0 shows the old value.
- Out-of-range: write 0x1FFF to address 20, then read address 20 → rdata=0 and rd_oob=1; address 4 is unchanged; the next write to address 4 still works.
- clear_req: fill entries with nonzero values, pulse clear_req.
  - ready drops for 16 cycles.
  - A write attempted during INIT is lost.
  - All entries read back INIT_VAL afterwards.
- Mid-init reset with RD_LATENCY=1: assert reset at init cycle 7.
  - ready stays 0 for a full 16 cycles after release.
  - rdata is 0 during reset and before the first registered read.
